// File: rtl/am27s25_arbiter.sv
// Two-requester burst fetch arbiter in front of a registered am27s25 PROM.
// Round-robin grant, sequential burst addressing, and a one-stage valid/owner/last pipeline aligned to PROM data.
module am27s25_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 9,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             a_req,
    input  logic [AW-1:0]    a_addr,
    input  logic [LW-1:0]    a_len,
    output logic             a_ack,
    output logic             a_vld,
    output logic             a_last,
    input  logic             b_req,
    input  logic [AW-1:0]    b_addr,
    input  logic [LW-1:0]    b_len,
    output logic             b_ack,
    output logic             b_vld,
    output logic             b_last,
    output logic [WIDTH-1:0] rdata,
    output logic [AW-1:0]    rom_a,
    output logic             rom_e1_,
    output logic             rom_e2_,
    output logic             rom_ps_,
    output logic             rom_clr_,
    input  logic [WIDTH-1:0] rom_q
);
    typedef enum logic [1:0] {INIT, IDLE, BURST} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [LW-1:0] cnt, cnt_nxt;
    logic          owner, owner_nxt;     // 0 = A, 1 = B
    logic          rr, rr_nxt;           // side of the most recent grant
    logic          ack_a, ack_b, ack_a_nxt, ack_b_nxt;
    logic          pv, po, pl;
    logic          owner_req, last_cyc, win, win_vld;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        rr_nxt    = rr;
        ack_a_nxt = 1'b0;
        ack_b_nxt = 1'b0;

        owner_req = owner ? b_req : a_req;
        last_cyc  = (state == BURST) && ((cnt == '0) || !owner_req);
        win_vld   = a_req | b_req;
        // On contention the side that did not win last time goes next.
        win       = (a_req && b_req) ? ~rr : b_req;

        case (state)
            INIT: state_nxt = IDLE;
            IDLE, BURST: begin
                if (state == IDLE || last_cyc) begin
                    if (win_vld) begin
                        state_nxt = BURST;
                        addr_nxt  = win ? b_addr : a_addr;
                        cnt_nxt   = win ? b_len : a_len;
                        owner_nxt = win;
                        rr_nxt    = win;
                        ack_a_nxt = ~win;
                        ack_b_nxt = win;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    addr_nxt = addr_q + AW'(1);
                    cnt_nxt  = cnt - LW'(1);
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state  <= INIT;
            addr_q <= '0;
            cnt    <= '0;
            owner  <= 1'b0;
            rr     <= 1'b1;
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            pv     <= 1'b0;
            po     <= 1'b0;
            pl     <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            cnt    <= cnt_nxt;
            owner  <= owner_nxt;
            rr     <= rr_nxt;
            ack_a  <= ack_a_nxt;
            ack_b  <= ack_b_nxt;
            // PROM data lags its address by one cycle; tag it to match.
            pv     <= (state == BURST);
            po     <= owner;
            pl     <= last_cyc;
        end
    end

    assign a_ack    = ack_a;
    assign b_ack    = ack_b;
    assign a_vld    = pv & ~po;
    assign b_vld    = pv & po;
    assign a_last   = a_vld & pl;
    assign b_last   = b_vld & pl;
    assign rdata    = rom_q;
    assign rom_a    = addr_q;
    assign rom_e1_  = ~pv;
    assign rom_e2_  = (state == INIT);
    assign rom_clr_ = (state != INIT);
    assign rom_ps_  = 1'b1;
endmodule
